// File: rtl/mdu_ctrl_if.sv
// Handshake and result bus between the E stage / hazard unit and the multiply/divide sequencer.
interface mdu_ctrl_if;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] A;
    logic [31:0] B;
    logic        D_md_use;
    logic        busy;
    logic        stall_req;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (
        output start, md_op, A, B, D_md_use,
        input  busy, stall_req, HI, LO
    );

    modport slave (
        input  start, md_op, A, B, D_md_use,
        output busy, stall_req, HI, LO
    );
endinterface

// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide sequencer owning HI/LO; a busy counter models the fixed
// operation latency and a stall request holds HI/LO-touching instructions in D.
module mdu_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    mdu_ctrl_if.slave   bus
);
    localparam int unsigned W  = 32;
    localparam int unsigned CW = 4;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    logic [CW-1:0] count;
    logic          busy_q;
    logic [W-1:0]  hi_q, lo_q;
    logic [W-1:0]  pend_hi, pend_lo;

    logic          is_mdu_op_c;
    logic          a_neg_c, b_neg_c;
    logic [W-1:0]  num_c, den_c, den_safe_c;
    logic [W-1:0]  uq_c, ur_c, quot_c, rem_c;
    logic [2*W-1:0] prod_s_c, prod_u_c, res_c;

    assign is_mdu_op_c = (bus.md_op == OP_MULT) || (bus.md_op == OP_MULTU) ||
                         (bus.md_op == OP_DIV)  || (bus.md_op == OP_DIVU);

    // Result datapath: one unsigned divider shared by div/divu via sign-magnitude fixup.
    always_comb begin
        a_neg_c    = (bus.md_op == OP_DIV) && bus.A[W-1];
        b_neg_c    = (bus.md_op == OP_DIV) && bus.B[W-1];
        num_c      = a_neg_c ? (~bus.A + W'(1)) : bus.A;
        den_c      = b_neg_c ? (~bus.B + W'(1)) : bus.B;
        den_safe_c = (den_c == '0) ? W'(1) : den_c;
        uq_c       = num_c / den_safe_c;
        ur_c       = num_c % den_safe_c;
        quot_c     = (a_neg_c ^ b_neg_c) ? (~uq_c + W'(1)) : uq_c;
        rem_c      = a_neg_c ? (~ur_c + W'(1)) : ur_c;
        prod_s_c   = {{W{bus.A[W-1]}}, bus.A} * {{W{bus.B[W-1]}}, bus.B};
        prod_u_c   = {W'(0), bus.A} * {W'(0), bus.B};

        res_c = '0;
        case (bus.md_op)
            OP_MULT:          res_c = prod_s_c;
            OP_MULTU:         res_c = prod_u_c;
            OP_DIV, OP_DIVU:  res_c = (bus.B == '0) ? {hi_q, lo_q} : {rem_c, quot_c};
            default:          res_c = '0;
        endcase
    end

    // Busy counter, pending result and committed HI/LO; starts while busy are ignored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count   <= '0;
            busy_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
        end else if (count != '0) begin
            count  <= count - CW'(1);
            busy_q <= (count != CW'(1));
            if (count == CW'(1)) begin
                hi_q <= pend_hi;
                lo_q <= pend_lo;
            end
        end else if (bus.start) begin
            case (bus.md_op)
                OP_MULT, OP_MULTU: begin
                    count   <= CW'(MULT_CYCLES);
                    busy_q  <= 1'b1;
                    pend_hi <= res_c[2*W-1:W];
                    pend_lo <= res_c[W-1:0];
                end
                OP_DIV, OP_DIVU: begin
                    count   <= CW'(DIV_CYCLES);
                    busy_q  <= 1'b1;
                    pend_hi <= res_c[2*W-1:W];
                    pend_lo <= res_c[W-1:0];
                end
                OP_MTHI: hi_q <= bus.A;
                OP_MTLO: lo_q <= bus.A;
                default: ;
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.HI        = hi_q;
    assign bus.LO        = lo_q;
    assign bus.stall_req = bus.D_md_use & (busy_q | (bus.start & is_mdu_op_c));
endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed test-plan cases plus a random op stream,
// compared cycle by cycle against a timeline-based arithmetic reference model.
module tb_mdu_ctrl;
    localparam int unsigned MULT_CYCLES = 5;
    localparam int unsigned DIV_CYCLES  = 10;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mdu_ctrl_if bus();

    mdu_ctrl #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model: committed registers plus one in-flight result with its issue cycle.
    int          cyc;
    logic [31:0] m_hi, m_lo, m_ph, m_pl;
    bit          m_pend;
    int          m_issue, m_lat;
    bit          last_stall;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    function automatic void model_result(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [31:0] cur_hi,
                                         input logic [31:0] cur_lo,
                                         output logic [31:0] rh, output logic [31:0] rl);
        longint          ps, x, y, q, r;
        longint unsigned pu;
        logic [63:0]     v;
        rh = cur_hi;
        rl = cur_lo;
        case (op)
            3'd1: begin
                ps = longint'($signed(a)) * longint'($signed(b));
                v  = ps;
                rh = v[63:32]; rl = v[31:0];
            end
            3'd2: begin
                pu = longint'(a) * longint'(b);
                v  = pu;
                rh = v[63:32]; rl = v[31:0];
            end
            3'd3: if (b != 0) begin
                x = longint'($signed(a));
                y = longint'($signed(b));
                q = x / y;
                r = x % y;
                v = q; rl = v[31:0];
                v = r; rh = v[31:0];
            end
            3'd4: if (b != 0) begin
                rl = a / b;
                rh = a % b;
            end
            default: ;
        endcase
    endfunction

    // One clock cycle: drive, predict, check, then advance the model across the edge.
    task automatic cycle(input logic st, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic du);
        logic exp_busy, exp_stall;
        bit   is_md;
        bus.start = st; bus.md_op = op; bus.A = a; bus.B = b; bus.D_md_use = du;
        if (m_pend && cyc == m_issue + m_lat + 1) begin
            m_hi = m_ph; m_lo = m_pl; m_pend = 0;
        end
        is_md     = (op >= 3'd1 && op <= 3'd4);
        exp_busy  = m_pend;
        exp_stall = du && (exp_busy || (st && is_md));
        #2;
        check("busy",  32'(bus.busy),      32'(exp_busy));
        check("stall", 32'(bus.stall_req), 32'(exp_stall));
        check("HI",    bus.HI, m_hi);
        check("LO",    bus.LO, m_lo);
        last_stall = bus.stall_req;
        if (st && !exp_busy) begin
            if (is_md) begin
                model_result(op, a, b, m_hi, m_lo, m_ph, m_pl);
                m_pend  = 1;
                m_issue = cyc;
                m_lat   = (op <= 3'd2) ? int'(MULT_CYCLES) : int'(DIV_CYCLES);
            end else if (op == 3'd5) m_hi = a;
            else if (op == 3'd6) m_lo = a;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n, input logic du);
        for (int i = 0; i < n; i++) cycle(1'b0, 3'd0, $urandom, $urandom, du);
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] pool [6];
        pool[0] = 32'h8000_0000; pool[1] = 32'hFFFF_FFFF; pool[2] = 32'h0;
        pool[3] = 32'h1;         pool[4] = 32'h7FFF_FFFF; pool[5] = 32'hFFFF_FFF9;
        if ($urandom_range(3) == 0) return pool[$urandom_range(5)];
        return $urandom;
    endfunction

    initial begin
        int stall_cnt;
        reset = 1'b1;
        bus.start = 0; bus.md_op = 0; bus.A = 0; bus.B = 0; bus.D_md_use = 0;
        cyc = 0; m_hi = 0; m_lo = 0; m_ph = 0; m_pl = 0; m_pend = 0; m_issue = 0; m_lat = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_HI",   bus.HI, 32'd0);
        check("rst_LO",   bus.LO, 32'd0);
        reset = 1'b0;

        // Directed test-plan cases.
        cycle(1'b1, 3'd1, 32'hFFFF_FFFE, 32'h0000_0003, 1'b0);
        idle(6, 1'b0);
        check("mult_HI", bus.HI, 32'hFFFF_FFFF);
        check("mult_LO", bus.LO, 32'hFFFF_FFFA);
        cycle(1'b1, 3'd2, 32'hFFFF_FFFE, 32'h0000_0003, 1'b0);
        idle(6, 1'b0);
        check("multu_HI", bus.HI, 32'h0000_0002);
        check("multu_LO", bus.LO, 32'hFFFF_FFFA);
        cycle(1'b1, 3'd3, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
        idle(11, 1'b0);
        check("div_HI", bus.HI, 32'hFFFF_FFFF);
        check("div_LO", bus.LO, 32'hFFFF_FFFD);
        cycle(1'b1, 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        idle(11, 1'b0);
        check("divovf_HI", bus.HI, 32'h0);
        check("divovf_LO", bus.LO, 32'h8000_0000);
        cycle(1'b1, 3'd5, 32'h0000_0011, 32'h0, 1'b1);
        check("mthi_HI", bus.HI, 32'h0000_0011);
        cycle(1'b1, 3'd6, 32'h0000_0022, 32'h0, 1'b1);
        check("mtlo_LO", bus.LO, 32'h0000_0022);
        cycle(1'b1, 3'd4, 32'h0000_0010, 32'h0, 1'b0);
        idle(11, 1'b0);
        check("div0_HI", bus.HI, 32'h0000_0011);
        check("div0_LO", bus.LO, 32'h0000_0022);

        // Stall window with D_md_use held, then back-to-back start in the first free cycle.
        stall_cnt = 0;
        cycle(1'b1, 3'd3, 32'd100, 32'd7, 1'b1);
        stall_cnt += int'(last_stall);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
            stall_cnt += int'(last_stall);
        end
        check("stall_len", 32'(stall_cnt), 32'd11);
        cycle(1'b1, 3'd1, 32'd6, 32'd7, 1'b0);
        check("b2b_stall12", 32'(last_stall), 32'd0);
        check("b2b_busy", 32'(bus.busy), 32'd1);
        idle(6, 1'b0);
        check("b2b_LO", bus.LO, 32'd42);

        // Asynchronous reset in the 4th busy cycle of a divide.
        cycle(1'b1, 3'd4, 32'd1000, 32'd3, 1'b1);
        idle(3, 1'b1);
        bus.D_md_use = 1'b1; bus.start = 1'b0;
        #2;
        check("pre_rst_busy", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        #1;
        check("arst_busy",  32'(bus.busy),      32'd0);
        check("arst_stall", 32'(bus.stall_req), 32'd0);
        check("arst_HI",    bus.HI, 32'd0);
        check("arst_LO",    bus.LO, 32'd0);
        m_hi = 0; m_lo = 0; m_pend = 0;
        @(posedge clk);
        #1;
        cyc++;
        reset = 1'b0;
        idle(14, 1'b1);

        // Random op stream, including starts issued while busy.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(2) == 0)
                cycle(1'b1, 3'($urandom_range(7)), pick_operand(), pick_operand(),
                      1'($urandom_range(1)));
            else
                cycle(1'b0, 3'($urandom_range(7)), $urandom, $urandom, 1'($urandom_range(1)));
        end
        idle(12, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Multi-cycle multiply/divide sequencer for the E stage of the 5-stage MIPS pipeline. It accepts mult/multu/div/divu/mthi/mtlo operations from the E stage and owns the HI/LO registers. It models the fixed operation latency with a busy counter and raises a stall request so the hazard unit holds any HI/LO-touching instruction in D until the result is committed.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu
- DIV_CYCLES, 10, busy cycles for div/divu

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  one-cycle pulse; the E-stage instruction is an MDU op and is not flushed
- md_op  in  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo; sampled only when start=1
- A  in  32  forwarded rs value from the E stage
- B  in  32  forwarded rt value from the E stage
- D_md_use  in  1  D-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo
- busy  out  1  operation in flight
- stall_req  out  1  to the hazard unit; freeze F/D and flush D2E
- HI  out  32  committed HI register
- LO  out  32  committed LO register

## Operation
- States: IDLE (count==0), BUSY (count!=0). busy = (count!=0), registered.
- Width rules:
  - count is 4 bits.
  - Results are computed combinationally at start and latched into pend_hi and pend_lo.
- Result encoding by op:
  - mult: {pend_hi,pend_lo} = $signed(A)*$signed(B), full 64 bits.
  - multu: the same product, unsigned.
  - div: pend_lo = quotient truncated toward zero; pend_hi = remainder with the sign of the dividend (A).
  - divu: the same, unsigned.
  - div with A=0x80000000, B=0xFFFFFFFF: pend_lo=0x80000000, pend_hi=0.
  - Divide by zero (div/divu, B==0): pend_hi=HI and pend_lo=LO. Commit therefore leaves HI/LO unchanged, but the full DIV_CYCLES busy period still applies.
- IDLE transitions on start:
  - mult/multu: count <= MULT_CYCLES, latch pend, go BUSY.
  - div/divu: count <= DIV_CYCLES, latch pend, go BUSY.
  - mthi: HI <= A at the next edge, stay IDLE, busy stays 0.
  - mtlo: LO <= A at the next edge, stay IDLE, busy stays 0.
  - md_op 0 or 7: no effect.
- BUSY: count decrements every edge. On the edge where count goes 1 -> 0, HI <= pend_hi, LO <= pend_lo, and the block returns to IDLE.
- start while BUSY is a protocol violation (stall_req prevents it). It is ignored: count, pend, HI and LO are untouched.
- stall_req = D_md_use & (busy | (start & md_op in {1,2,3,4})). It is combinational from start and registered busy.
- mfhi/mflo read HI/LO directly. No bypass of pending results is needed, because stall_req keeps them in D until commit.

## Timing
- Reset values: busy=0, stall_req=0 (when no start), HI=0, LO=0, count=0, pend_hi=pend_lo=0.
- reset asserted mid-operation clears everything immediately, without waiting for a clock edge. The pending result is discarded.
- Multiply, with start high in cycle t:
  - busy is high in cycles t+1 .. t+MULT_CYCLES.
  - New HI/LO are visible from cycle t+MULT_CYCLES+1, the same cycle busy falls.
- Divide follows the same pattern with DIV_CYCLES.
- stall_req with D_md_use held high: asserted in cycle t, then through the busy period. Total 1+MULT_CYCLES or 1+DIV_CYCLES cycles.
- Back-to-back: a new start is accepted in the first cycle busy=0. There is no idle bubble.
- mthi/mtlo: latency 1 edge. stall_req is never raised by them.

## Test plan
- mult, A=0xFFFFFFFE, B=0x00000003:
  - busy high exactly 5 cycles.
  - Then HI=0xFFFFFFFF, LO=0xFFFFFFFA; HI/LO are unchanged during busy.
- multu, same operands: after 5 cycles HI=0x00000002, LO=0xFFFFFFFA.
- div, A=0xFFFFFFF9 (-7), B=0x00000002: busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- divu by zero (A=0x10, B=0) with HI=0x11, LO=0x22 preloaded via mthi/mtlo:
  - busy 10 cycles.
  - HI=0x11, LO=0x22 afterwards.
  - Each mthi/mtlo updates one edge after its start, and busy never rises for them.
- Stall window: div start with D_md_use=1 held → stall_req high for exactly 11 consecutive cycles, low on the 12th. A second start issued in the 12th cycle is accepted.
- Reset mid-div, asserted asynchronously between edges in the 4th busy cycle:
  - busy, stall_req, HI and LO go to 0 before the next edge.
  - After release, no commit ever occurs.
